stage_execute: RTL
==================

# stage_execute

Final stage of the brainfuck pipeline. Consumes the decoded operation and its operand `a` from the data-fetch stage. It performs:
- DRAM write-back for `+`, `-` and `,`;
- the byte-output handshake for `.`;
- the taken/not-taken decision for `[` and `]`.

It throttles the data-fetch stage through `ack`. It inserts one interlock cycle after every DRAM write, so the next fetch reads the updated cell.

## Interface
Parameters:
- `A_WIDTH`, 12, DRAM address width (width of `dp`).
- `D_WIDTH`, 8, DRAM cell width (width of `a`).

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `operation`  in  `OPCODE_MSB+1`  one-hot opcode from data-fetch stage; all-zero means bubble.
- `a`  in  `D_WIDTH`  operand fetched for `operation`: cell value, or input byte for `OP_IN`.
- `ack`  out  1  operation consumed this cycle; upstream advances on the edge.
- `dp`  in  `A_WIDTH`  current data pointer.
- `dwe`  out  1  DRAM write enable, written at rising edge.
- `dwa`  out  `A_WIDTH`  DRAM write address.
- `dwd`  out  `D_WIDTH`  DRAM write data.
- `xd`  out  8  output byte to external channel.
- `xwr`  out  1  output byte valid.
- `xack`  in  1  external channel accepts `xd`.
- `loop_fwd`  out  1  strobe: `[` taken (cell zero), fetch must skip past matching `]`.
- `loop_back`  out  1  strobe: `]` taken (cell nonzero), fetch must return to matching `[`.

## Operation
FSM states: `EXEC` (reset state), `WB_HOLD`, `OUT_WAIT`.

`EXEC` — decode `operation`, priority write ops > `OP_OUT` > loop ops > others:
- `OP_INC`: `dwe`=1, `dwd`=`a`+1 mod 2^D_WIDTH, `dwa`=`dp`, `ack`=0, next `WB_HOLD`.
- `OP_DEC`: same with `a`−1 mod 2^D_WIDTH (0x00 → 0xFF).
- `OP_IN`: same with `dwd`=`a`.
- `OP_OUT`: `ack`=0; register `xd`<=`a[7:0]` (zero-extended if `D_WIDTH`<8), `xwr`<=1; next `OUT_WAIT`.
- `OP_LOOPBEGIN`: `ack`=1; `loop_fwd`=1 iff `a`==0.
- `OP_LOOPEND`: `ack`=1; `loop_back`=1 iff `a`!=0.
- `OP_INCDP`, `OP_DECDP`, bubble, any other: `ack`=1, no side effect.

`WB_HOLD`:
- `dwe`=0, `ack`=1; next `EXEC`.
- The held write op is retired here, not re-executed.

`OUT_WAIT`:
- `xwr` held 1, `xd` held stable; `ack` = `xack`.
- On `xack`=1: `xwr`<=0, next `EXEC`.
- Otherwise remain, indefinitely.

Rules in every state:
- `dwe`, `loop_fwd` and `loop_back` are combinational and asserted only in `EXEC`; each lasts exactly one cycle per operation.
- `dwa` = `dp` at all times; `dwd` = 0 when `dwe`=0.
- Integration contract: while `ack`=0, upstream holds `operation`, `a` and `dp` stable.

## Timing
- Reset values: state `EXEC`, `xwr`=0, `xd`=0. Combinational outputs follow a reset (all-zero) `operation`: `dwe`=0, `loop_*`=0, `ack`=1.
- Latency: non-write, non-output ops take 1 cycle; `+`/`-`/`,` take 2 cycles (write, hold); `.` takes 1 + cycles until `xack`, minimum 2.
- `xack` while `xwr`=0 is ignored.
- `xack` already high when `OUT_WAIT` is entered: completes in the first `OUT_WAIT` cycle.
- Reset asserted in `OUT_WAIT` or `WB_HOLD`: `xwr` drops asynchronously; the byte is abandoned, not retried.
- Back-to-back `.`: `xwr` deasserts for at least one cycle between bytes.
- Illegal multi-hot `operation`: only the highest-priority op executes.

## Structure
- Opcode bit indices (`OP_*`) and `OPCODE_MSB` come from the shared constants include; add no new opcode definitions.
- State encodings are local parameters.
- One natural sub-module: `out_port_reg`, holding the `xd`/`xwr` register and the `xack` handshake.

## Test plan
- Reset mid-`OUT_WAIT` with `xwr`=1 → `xwr`=0 asynchronously, before the next clock edge; FSM in `EXEC`.
- `OP_INC`, `a`=0xFF, `dp`=0x123 → cycle 1: `dwe`=1, `dwa`=0x123, `dwd`=0x00, `ack`=0; cycle 2: `dwe`=0, `ack`=1; single write total.
- `OP_DEC`, `a`=0x00 → `dwd`=0xFF; `OP_IN`, `a`=0x41 → `dwd`=0x41; each 2 cycles.
- `OP_OUT`, `a`=0x48, `xack` low for 5 cycles then high → `xd`=0x48, `xwr`=1 for 6 cycles, `ack`=1 only in the `xack` cycle, `xwr`=0 after.
- `OP_LOOPBEGIN` with `a`=0 → `loop_fwd` one cycle; with `a`=7 → none. `OP_LOOPEND` with `a`=7 → `loop_back`; with `a`=0 → none. `ack`=1 throughout.
- Sequence bubble, `OP_INCDP`, `OP_INC`, `OP_OUT` → `ack` pattern 1,1,0,1,0,…,1; no `dwe` on bubble or `OP_INCDP`.

Source files
------------

// File: rtl/stage_execute_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stage_execute_pkg
// Purpose  : Shared opcode bit indices for the brainfuck pipeline and the
//            priority decode used by the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
package stage_execute_pkg;

  // One-hot opcode bit positions shared by every pipeline stage.
  localparam int OP_INC       = 0;  // '+'
  localparam int OP_DEC       = 1;  // '-'
  localparam int OP_INCDP     = 2;  // '>'
  localparam int OP_DECDP     = 3;  // '<'
  localparam int OP_OUT       = 4;  // '.'
  localparam int OP_IN        = 5;  // ','
  localparam int OP_LOOPBEGIN = 6;  // '['
  localparam int OP_LOOPEND   = 7;  // ']'
  localparam int OPCODE_MSB   = 7;

  // Action selected by the execute stage for one operation slot.
  typedef enum logic [2:0] {
    ACT_NONE       = 3'd0,
    ACT_INC        = 3'd1,
    ACT_DEC        = 3'd2,
    ACT_IN         = 3'd3,
    ACT_OUT        = 3'd4,
    ACT_LOOP_BEGIN = 3'd5,
    ACT_LOOP_END   = 3'd6
  } exec_act_e;

  // Priority decode: DRAM writes first, then output, then loop control.
  // A multi-hot opcode therefore executes only its highest-priority member.
  function automatic exec_act_e decode_op(input logic [OPCODE_MSB:0] op);
    exec_act_e act;
    act = ACT_NONE;
    if (op[OP_INC])                      act = ACT_INC;
    else if (op[OP_DEC])                 act = ACT_DEC;
    else if (op[OP_IN])                  act = ACT_IN;
    else if (op[OP_OUT])                 act = ACT_OUT;
    else if (op[OP_LOOPBEGIN])           act = ACT_LOOP_BEGIN;
    else if (op[OP_LOOPEND])             act = ACT_LOOP_END;
    else if (op[OP_INCDP] || op[OP_DECDP]) act = ACT_NONE;  // pointer ops retire here with no effect
    return act;
  endfunction

endpackage : stage_execute_pkg
`default_nettype wire

// File: rtl/stage_execute_out_port_reg.sv
`default_nettype none
// ============================================================================
// Module   : out_port_reg
// Purpose  : Output byte register with valid/accept handshake.
//            A load captures the byte and raises xwr; xwr falls on the edge
//            where xack is seen while xwr is high. xack with xwr low is
//            ignored.
// Ports    : clk, reset      - clock, asynchronous active-high reset
//            load, load_data - capture a new byte and raise xwr
//            xack            - external channel accepts xd
//            xd, xwr         - registered byte and its valid flag
//            done            - handshake completes this cycle (xwr & xack)
// Revision : 1.0 - initial release
// ============================================================================
module out_port_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       xack,
  output logic [7:0] xd,
  output logic       xwr,
  output logic       done
);

  logic [7:0] xd_q,  xd_d;
  logic       xwr_q, xwr_d;

  always_comb begin
    xd_d  = xd_q;
    xwr_d = xwr_q;
    if (load) begin
      xd_d  = load_data;
      xwr_d = 1'b1;
    end else if (xwr_q && xack) begin
      // xd keeps its last value; only the valid flag drops.
      xwr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xd_q  <= 8'h00;
      xwr_q <= 1'b0;
    end else begin
      xd_q  <= xd_d;
      xwr_q <= xwr_d;
    end
  end

  assign xd   = xd_q;
  assign xwr  = xwr_q;
  assign done = xwr_q & xack;

endmodule : out_port_reg
`default_nettype wire

// File: rtl/stage_execute.sv
`default_nettype none
// ============================================================================
// Module   : stage_execute
// Purpose  : Final stage of the brainfuck pipeline. Performs DRAM write-back
//            for '+', '-', ',', the byte-output handshake for '.', and the
//            taken decision for '[' / ']'. Every DRAM write is followed by
//            one hold cycle so the next fetch reads the updated cell.
// Ports    : clk, reset           - clock, asynchronous active-high reset
//            operation, a, dp     - one-hot op, operand and data pointer
//            ack                  - operation consumed this cycle
//            dwe, dwa, dwd        - DRAM write port
//            xd, xwr, xack        - output byte channel
//            loop_fwd, loop_back  - loop-taken strobes to fetch
// Revision : 1.0 - initial release
// ============================================================================
module stage_execute
  import stage_execute_pkg::*;
#(
  parameter int A_WIDTH = 12,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPCODE_MSB:0] operation,
  input  logic [D_WIDTH-1:0] a,
  output logic               ack,
  input  logic [A_WIDTH-1:0] dp,
  output logic               dwe,
  output logic [A_WIDTH-1:0] dwa,
  output logic [D_WIDTH-1:0] dwd,
  output logic [7:0]         xd,
  output logic               xwr,
  input  logic               xack,
  output logic               loop_fwd,
  output logic               loop_back
);

  localparam logic [1:0] S_EXEC     = 2'd0;
  localparam logic [1:0] S_WB_HOLD  = 2'd1;
  localparam logic [1:0] S_OUT_WAIT = 2'd2;

  typedef enum logic [1:0] {
    EXEC     = S_EXEC,
    WB_HOLD  = S_WB_HOLD,
    OUT_WAIT = S_OUT_WAIT
  } state_e;

  state_e     state_q, state_d;
  exec_act_e  act;
  logic       out_load;
  logic       out_done;
  logic [7:0] out_byte;

  // Output channel is always one byte wide; narrow cells are zero-extended.
  generate
    if (D_WIDTH >= 8) begin : g_byte_trunc
      assign out_byte = a[7:0];
    end else begin : g_byte_zext
      assign out_byte = {{(8 - D_WIDTH){1'b0}}, a};
    end
  endgenerate

  assign act = decode_op(operation);
  assign dwa = dp;

  always_comb begin
    state_d   = state_q;
    ack       = 1'b1;
    dwe       = 1'b0;
    dwd       = '0;
    loop_fwd  = 1'b0;
    loop_back = 1'b0;
    out_load  = 1'b0;

    case (state_q)
      EXEC: begin
        case (act)
          ACT_INC: begin
            dwe     = 1'b1;
            dwd     = a + 1'b1;
            ack     = 1'b0;
            state_d = WB_HOLD;
          end
          ACT_DEC: begin
            dwe     = 1'b1;
            dwd     = a - 1'b1;
            ack     = 1'b0;
            state_d = WB_HOLD;
          end
          ACT_IN: begin
            dwe     = 1'b1;
            dwd     = a;
            ack     = 1'b0;
            state_d = WB_HOLD;
          end
          ACT_OUT: begin
            ack      = 1'b0;
            out_load = 1'b1;
            state_d  = OUT_WAIT;
          end
          ACT_LOOP_BEGIN: loop_fwd  = (a == '0);
          ACT_LOOP_END:   loop_back = (a != '0);
          default: ;
        endcase
      end

      // The write already happened in EXEC; this cycle only retires the op
      // so the following fetch sees the updated cell.
      WB_HOLD: state_d = EXEC;

      OUT_WAIT: begin
        ack = out_done;
        if (out_done) state_d = EXEC;
      end

      default: state_d = EXEC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EXEC;
    else       state_q <= state_d;
  end

  out_port_reg u_out_port_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (out_load),
    .load_data (out_byte),
    .xack      (xack),
    .xd        (xd),
    .xwr       (xwr),
    .done      (out_done)
  );

endmodule : stage_execute
`default_nettype wire
